ysyx_22041207_pipe_ctrl: RTL

YSYX_22041207_PIPE_CTRL -- requirements
Module: ysyx_22041207_pipe_ctrl

---
 rtl/ysyx_22041207_pipe_pkg.sv | 22 ++
 rtl/ysyx_22041207_hazard_detect.sv | 23 ++
 rtl/ysyx_22041207_pipe_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_pipe_pkg.sv
// rtl/ysyx_22041207_pipe_pkg.sv - shared types and constants for the pipeline controller
package ysyx_22041207_pipe_pkg;

  // Controller states; RUN must stay at zero so a cleared register is a safe state
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  // Extra stall cycles spent in LU_STALL after the first load-use stall cycle in RUN
  localparam logic [1:0] LU_STALL_LEN = 2'd1;

  typedef logic [4:0] reg_addr_t;

  // One source operand depends on the EX destination
  function automatic logic src_match(input logic use_src, input reg_addr_t src,
                                     input reg_addr_t dst);
    return use_src & (src == dst);
  endfunction

endpackage

// File: rtl/ysyx_22041207_hazard_detect.sv
// rtl/ysyx_22041207_hazard_detect.sv - combinational load-use hazard comparator
module ysyx_22041207_hazard_detect
  import ysyx_22041207_pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1addr,
  input  logic [4:0] id_rs2addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rwaddr,
  input  logic       ex_writeRD,
  input  logic       ex_memoryReadWen,
  output logic       hz
);

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  always_comb begin
    hz = id_valid & ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 5'd0) &
         (src_match(id_use_rs1, id_rs1addr, ex_rwaddr) |
          src_match(id_use_rs2, id_rs2addr, ex_rwaddr));
  end

endmodule

// File: rtl/ysyx_22041207_pipe_ctrl.sv
// rtl/ysyx_22041207_pipe_ctrl.sv - pipeline stall/flush controller; YSYX_22041207_LOADUSE_FWD_EN shortens load-use stall to 1 cycle
module ysyx_22041207_pipe_ctrl
  import ysyx_22041207_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1addr,
  input  logic [4:0]  id_rs2addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rwaddr,
  input  logic        ex_writeRD,
  input  logic        ex_memoryReadWen,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  input  logic        mdu_done,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_flush,
  output logic        clear_afterID,
  output logic        ex_mem_bubble,
  output logic        ex_mem_clear,
  output logic [31:0] stall_cnt
);

  state_e      state_q, state_d;
  logic [1:0]  lu_cnt_q, lu_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        hz;

  ysyx_22041207_hazard_detect u_hazard_detect (
    .id_valid         (id_valid),
    .id_rs1addr       (id_rs1addr),
    .id_rs2addr       (id_rs2addr),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .ex_rwaddr        (ex_rwaddr),
    .ex_writeRD       (ex_writeRD),
    .ex_memoryReadWen (ex_memoryReadWen),
    .hz               (hz)
  );

  // Control outputs and next state; a stalled memory freezes everything ahead of the FSM
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_flush   = 1'b0;
    clear_afterID = 1'b0;
    ex_mem_bubble = 1'b0;
    ex_mem_clear  = 1'b0;
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;

    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            clear_afterID = 1'b1;
          end
          if (ex_mdu_start) begin
            state_d = ST_MDU_WAIT;
          end
`ifndef YSYX_22041207_LOADUSE_FWD_EN
          else if (hz && !ex_redirect) begin
            state_d  = ST_LU_STALL;
            lu_cnt_d = LU_STALL_LEN;
          end
`endif
        end
        ST_LU_STALL: begin
          if (lu_cnt_q != 2'd0) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            clear_afterID = 1'b1;
            lu_cnt_d      = lu_cnt_q - 2'd1;
            if (lu_cnt_q == 2'd1) begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MDU_WAIT: begin
          if (mdu_done) begin
            state_d = ST_RUN;
          end else begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_clear = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Stall cycle counter, free-running with natural 32-bit wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      lu_cnt_q    <= 2'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
